vote_collector: RTL

- Upstream stage of the 5-input majority circuit.
- Runs one voting round per start pulse: collects one ballot bit from each of 5 independent voters over per-voter valid strobes, with a timeout.
- Presents a registered, stable 5-bit vector x[5:1] plus a one-cycle x_valid pulse; x connects directly to the majority circuit's x input.
- Reports which voters failed to respond.

---
 rtl/vote_collector.sv | 127 ++++++++++++
 1 files changed

// File: rtl/vote_collector.sv
// Five-voter ballot collector: one round per start pulse, with timeout.
// Presents a registered ballot vector and a one-cycle valid to the majority stage.
module vote_collector #(
   parameter int unsigned TIMEOUT      = 16,
   parameter logic        DEFAULT_VOTE = 1'b0,
   parameter int unsigned TMR_W        = $clog2(TIMEOUT + 1)
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [5:1] vote_valid,
   input  logic [5:1] vote_bit,
   output logic       busy,
   output logic [5:1] x,
   output logic       x_valid,
   output logic [5:1] missing,
   output logic       timeout_flag
);

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      DONE
   } state_e;

   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

   state_e           state_q, state_d;
   logic [5:1]       recv_q, recv_d;
   logic [5:1]       ballot_q, ballot_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic [5:1]       x_q, x_d;
   logic [5:1]       miss_q, miss_d;
   logic             to_q, to_d;
   logic             xv_q, xv_d;
   logic             busy_q, busy_d;

   logic [5:1]       new_v;
   logic [5:1]       got;
   logic [5:1]       bal_n;

   // Only a voter's first strobe of the round is captured.
   assign new_v = vote_valid & ~recv_q;
   assign got   = recv_q | new_v;
   assign bal_n = (ballot_q & ~new_v) | (vote_bit & new_v);

   always_comb begin
      state_d  = state_q;
      recv_d   = recv_q;
      ballot_d = ballot_q;
      timer_d  = timer_q;
      x_d      = x_q;
      miss_d   = miss_q;
      to_d     = to_q;
      xv_d     = 1'b0;
      busy_d   = busy_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               recv_d   = '0;
               ballot_d = '0;
               timer_d  = '0;
               busy_d   = 1'b1;
               state_d  = COLLECT;
            end
         end
         COLLECT: begin
            recv_d   = got;
            ballot_d = bal_n;
            if (&got) begin
               x_d     = bal_n;
               miss_d  = '0;
               to_d    = 1'b0;
               xv_d    = 1'b1;
               state_d = DONE;
            end else if (timer_q == TMR_LAST) begin
               x_d     = (bal_n & got) | ({5{DEFAULT_VOTE}} & ~got);
               miss_d  = ~got;
               to_d    = 1'b1;
               xv_d    = 1'b1;
               state_d = DONE;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         recv_q   <= '0;
         ballot_q <= '0;
         timer_q  <= '0;
         x_q      <= '0;
         miss_q   <= '0;
         to_q     <= 1'b0;
         xv_q     <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         recv_q   <= recv_d;
         ballot_q <= ballot_d;
         timer_q  <= timer_d;
         x_q      <= x_d;
         miss_q   <= miss_d;
         to_q     <= to_d;
         xv_q     <= xv_d;
         busy_q   <= busy_d;
      end
   end

   assign busy         = busy_q;
   assign x            = x_q;
   assign x_valid      = xv_q;
   assign missing      = miss_q;
   assign timeout_flag = to_q;

endmodule
